// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
//   state_t   : monitor state (waiting for first rise / measuring a period)
//   high_min  : shortest acceptable high time for a given division ratio
//   high_max  : longest acceptable high time for a given division ratio
//   cnt_max   : all-ones value of a counter of the given width (timeout point)
package div_mon_pkg;

    typedef enum logic {
        WAIT_RISE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    function automatic int high_min(input int div);
        return div / 2;
    endfunction

    function automatic int high_max(input int div);
        return (div + 1) / 2;
    endfunction

    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises a single-bit input into the clk domain and flags its edges.
//   clk  : sampling clock, rising edge
//   rst  : asynchronous active-low reset
//   d    : input to watch (may be asynchronous to clk)
//   rise : one-cycle pulse, synchronised d went 0 -> 1
//   fall : one-cycle pulse, synchronised d went 1 -> 0
// Edge latency from a d transition to rise/fall is SYNC_STAGES+1 clk cycles.
// SYNC_STAGES=0 is only safe when d is itself generated from clk.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s;
    logic s_d;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/div_clk_monitor.sv
// Receive-side checker for a divided clock: measures period and high time of
// div_clk in clk cycles, reports lock to EXPECTED_DIV and flags bad periods
// and a stuck (edge-less) div_clk.
//   clk        : source clock, all logic on rising edge
//   rst        : asynchronous active-low reset
//   en         : monitor enable; low abandons the current measurement
//   div_clk    : divided clock under test
//   period_o   : last measured period in clk cycles
//   high_o     : last measured high time in clk cycles
//   meas_valid : one-cycle pulse when period_o/high_o update
//   locked     : LOCK_COUNT consecutive good periods seen
//   mismatch   : one-cycle pulse (with meas_valid) on a bad period
//   stuck      : no rising edge within 2^CNT_W-1 cycles; cleared by next rise
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int EXPECTED_DIV = 9,
    parameter int LOCK_COUNT   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int CHECK_DUTY   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             stuck
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] EXP_PER  = CNT_W'(EXPECTED_DIV);
    localparam logic [CNT_W-1:0] HIGH_MIN = CNT_W'(high_min(EXPECTED_DIV));
    localparam logic [CNT_W-1:0] HIGH_MAX = CNT_W'(high_max(EXPECTED_DIV));
    localparam logic [MC_W-1:0]  LOCK_TGT = MC_W'(LOCK_COUNT);

    logic rise;
    logic fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk (clk),
        .rst (rst),
        .d   (div_clk),
        .rise(rise),
        .fall(fall)
    );

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cap;
    logic             fall_seen;
    logic [MC_W-1:0]  match_cnt;

    logic             duty_ok;
    logic             good_period;
    logic [MC_W-1:0]  match_inc;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first) so no latch is inferred.
    always_comb begin
        duty_ok     = (hi_cap >= HIGH_MIN) && (hi_cap <= HIGH_MAX);
        good_period = (cnt == EXP_PER) && fall_seen &&
                      ((CHECK_DUTY == 0) || duty_ok);
        // Saturate so a long run of good periods keeps locked asserted.
        match_inc   = (match_cnt == LOCK_TGT) ? match_cnt : match_cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= WAIT_RISE;
            cnt        <= '0;
            hi_cap     <= '0;
            fall_seen  <= 1'b0;
            match_cnt  <= '0;
            period_o   <= '0;
            high_o     <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            mismatch   <= 1'b0;

            if (!en) begin
                // Abandon any partial period; results and stuck are kept.
                state     <= WAIT_RISE;
                cnt       <= '0;
                fall_seen <= 1'b0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    WAIT_RISE: begin
                        // The partial period before this rise is discarded.
                        cnt <= '0;
                        if (rise) begin
                            cnt       <= CNT_W'(1);
                            fall_seen <= 1'b0;
                            stuck     <= 1'b0;
                            state     <= MEASURE;
                        end
                    end

                    MEASURE: begin
                        // A rise takes priority over a coincident timeout.
                        if (rise) begin
                            period_o   <= cnt;
                            high_o     <= hi_cap;
                            meas_valid <= 1'b1;
                            cnt        <= CNT_W'(1);
                            fall_seen  <= 1'b0;
                            stuck      <= 1'b0;
                            if (good_period) begin
                                match_cnt <= match_inc;
                                if (match_inc == LOCK_TGT) begin
                                    locked <= 1'b1;
                                end
                            end else begin
                                match_cnt <= '0;
                                locked    <= 1'b0;
                                mismatch  <= 1'b1;
                            end
                        end else if (cnt == CNT_TOP) begin
                            stuck     <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            cnt       <= '0;
                            state     <= WAIT_RISE;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (fall) begin
                                // cnt here equals the number of high cycles.
                                hi_cap    <= cnt;
                                fall_seen <= 1'b1;
                            end
                        end
                    end

                    default: state <= WAIT_RISE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
module tb_div_clk_monitor;

    localparam int CNT_W = 8;
    localparam int EXP   = 9;
    localparam int LOCKN = 4;
    localparam int CMAX  = 255;

    logic clk = 1'b1;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic div_clk = 1'b0;

    logic [CNT_W-1:0] period_a, high_a, period_b, high_b;
    logic mv_a, locked_a, mm_a, stuck_a;
    logic mv_b, locked_b, mm_b, stuck_b;

    always #5 clk = ~clk;

    div_clk_monitor #(
        .CNT_W(CNT_W), .EXPECTED_DIV(EXP), .LOCK_COUNT(LOCKN),
        .SYNC_STAGES(2), .CHECK_DUTY(0)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .div_clk(div_clk),
        .period_o(period_a), .high_o(high_a), .meas_valid(mv_a),
        .locked(locked_a), .mismatch(mm_a), .stuck(stuck_a)
    );

    div_clk_monitor #(
        .CNT_W(CNT_W), .EXPECTED_DIV(EXP), .LOCK_COUNT(LOCKN),
        .SYNC_STAGES(2), .CHECK_DUTY(1)
    ) u_duty (
        .clk(clk), .rst(rst), .en(en), .div_clk(div_clk),
        .period_o(period_b), .high_o(high_b), .meas_valid(mv_b),
        .locked(locked_b), .mismatch(mm_b), .stuck(stuck_b)
    );

    typedef struct {
        int period;
        int high;
        bit mismatch;
        bit locked;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: whether the next rise completes a period, the
    // good-period run length per instance, and the period now in progress.
    bit armed = 1'b0;
    int run_a = 0;
    int run_b = 0;
    int prev_h = 0;
    int prev_len = 0;
    int last_period = 0;
    int last_high = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_good(input int p, input int h, input bit duty);
        return (p == EXP) && (!duty || h == EXP / 2 || h == (EXP + 1) / 2);
    endfunction

    // Called at every div_clk rise the bench drives.
    task automatic model_rise();
        exp_t e;
        bit g;
        if (armed && prev_len <= CMAX) begin
            g = is_good(prev_len, prev_h, 1'b0);
            run_a = g ? ((run_a < LOCKN) ? run_a + 1 : LOCKN) : 0;
            e.period = prev_len; e.high = prev_h; e.mismatch = !g; e.locked = (run_a == LOCKN);
            q_a.push_back(e);
            g = is_good(prev_len, prev_h, 1'b1);
            run_b = g ? ((run_b < LOCKN) ? run_b + 1 : LOCKN) : 0;
            e.mismatch = !g; e.locked = (run_b == LOCKN);
            q_b.push_back(e);
            last_period = prev_len;
            last_high   = prev_h;
        end else if (armed) begin
            // Period too long: timeout fired, this rise only re-arms.
            run_a = 0;
            run_b = 0;
        end
        armed = 1'b1;
    endtask

    // One div_clk period: high for h clk cycles then low for l; entered and
    // left just after a rising clk edge.
    task automatic drive(input int h, input int l);
        model_rise();
        prev_h   = h;
        prev_len = h + l;
        div_clk  = 1'b1;
        repeat (h) @(posedge clk);
        #1 div_clk = 1'b0;
        repeat (l) @(posedge clk);
        #1;
    endtask

    task automatic ideal(input int n);
        for (int i = 0; i < n; i++) drive((i % 2 == 0) ? 4 : 5, (i % 2 == 0) ? 5 : 4);
    endtask

    // Hold div_clk low after one rise; stuck must appear 255 cycles after the
    // rise is seen, which is 3 cycles of edge latency after it is driven.
    task automatic stuck_test();
        model_rise();
        prev_h   = 5;
        prev_len = 300;
        div_clk  = 1'b1;
        repeat (5) @(posedge clk);
        #1 div_clk = 1'b0;
        repeat (252) @(posedge clk);
        #1 check("stuck_early", stuck_a, 0);
        @(posedge clk);
        #1 check("stuck_set", stuck_a, 1);
        check("stuck_locked", locked_a, 0);
        check("stuck_duty", stuck_b, 1);
        repeat (42) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid();
        model_rise();
        prev_h   = 5;
        prev_len = 9;
        div_clk  = 1'b1;
        repeat (5) @(posedge clk);
        check("pre_reset_locked", locked_a, run_a == LOCKN);
        #2 rst = 1'b0;
        #1;
        check("rst_period", period_a, 0);
        check("rst_high", high_a, 0);
        check("rst_valid", mv_a, 0);
        check("rst_locked", locked_a, 0);
        check("rst_mismatch", mm_a, 0);
        check("rst_stuck", stuck_a, 0);
        check("rst_queue", q_a.size(), 0);
        div_clk = 1'b0;
        armed = 1'b0;
        run_a = 0;
        run_b = 0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic en_drop();
        check("en_pre_locked", locked_a, run_a == LOCKN);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_locked", locked_a, 0);
        check("en_period_hold", period_a, last_period);
        check("en_high_hold", high_a, last_high);
        armed = 1'b0;
        run_a = 0;
        run_b = 0;
        repeat (19) @(posedge clk);
        #1 en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: compare whenever an instance presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (mv_a) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_valid: period %0d with nothing expected at %0t", period_a, $time);
            end else begin
                e = q_a.pop_front();
                check("a_period", period_a, e.period);
                check("a_high", high_a, e.high);
                check("a_mismatch", mm_a, e.mismatch);
                check("a_locked", locked_a, e.locked);
            end
        end else if (mm_a) begin
            check("a_mismatch_no_valid", mm_a, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mv_b) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_valid: period %0d with nothing expected at %0t", period_b, $time);
            end else begin
                e = q_b.pop_front();
                check("b_period", period_b, e.period);
                check("b_high", high_b, e.high);
                check("b_mismatch", mm_b, e.mismatch);
                check("b_locked", locked_b, e.locked);
            end
        end else if (mm_b) begin
            check("b_mismatch_no_valid", mm_b, 0);
        end
    end

    initial begin
        #2;
        check("reset_period", period_a, 0);
        check("reset_valid", mv_a, 0);
        check("reset_locked", locked_a, 0);
        check("reset_stuck", stuck_a, 0);
        check("reset_locked_duty", locked_b, 0);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Ideal divide-by-9, then a single 10-cycle period.
        ideal(7);
        drive(5, 5);
        ideal(6);

        // div_clk stops, then resumes.
        stuck_test();
        drive(4, 5);
        check("stuck_cleared", stuck_a, 0);
        ideal(6);

        // Duty-check instance: high 2 fails, high 4 and high 5 lock.
        repeat (5) drive(2, 7);
        repeat (6) drive(4, 5);
        repeat (6) drive(5, 4);

        reset_mid();
        ideal(7);

        en_drop();
        ideal(7);

        // Longest measurable period, then one that times out.
        drive(100, 155);
        drive(100, 156);
        ideal(6);

        for (int i = 0; i < 150; i++) begin
            int r, p, h;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                p = EXP;
                h = $urandom_range(4, 5);
            end else if (r < 8) begin
                p = EXP;
                h = $urandom_range(1, EXP - 1);
            end else begin
                p = $urandom_range(2, 20);
                h = $urandom_range(1, p - 1);
            end
            drive(h, p - h);
        end
        drive(4, 5);
        repeat (6) @(posedge clk);
        #1;
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
